mem_bus_arbiter: RTL and testbench

//  Shares one single-ported memory bus between instruction fetch (IF side, pc_reg/if_id) and data

---
 rtl/mem_bus_arbiter_pkg.sv | 15 +
 rtl/mem_bus_arbiter_result_buf.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and state type for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;
  localparam int SW_DEF = DW_DEF / 8;

  // Bus ownership: idle, serving the data side, or serving instruction fetch.
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_DATA = 2'd1,
    BUS_INST = 2'd2
  } bus_state_e;

endpackage

// File: rtl/mem_bus_arbiter_result_buf.sv
// Per-side result buffer: holds a completed bus result until the pipeline
// advances, and forwards the live bus data when nothing is buffered.
module arb_result_buf
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_i,
  input  logic          ack_i,
  input  logic          discard_i,
  input  logic          advance_i,
  input  logic          flush_i,
  input  logic          keep_data_i,
  input  logic [DW-1:0] bus_data_i,
  output logic [DW-1:0] data_o,
  output logic          vld_o,
  output logic          stallreq_o
);

  logic          vld_q, vld_d;
  logic [DW-1:0] buf_q, buf_d;

  // Next-state: flush or advance empties the buffer and beats a fill on the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    vld_d = vld_q;
    buf_d = buf_q;
    if (flush_i || advance_i) begin
      vld_d = 1'b0;
    end else if (ack_i && !discard_i) begin
      vld_d = 1'b1;
      if (!keep_data_i) buf_d = bus_data_i;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments; the data register is reset too so
    // the output mux never sees X after reset.
    if (!rst) begin
      vld_q <= 1'b0;
      buf_q <= '0;
    end else begin
      vld_q <= vld_d;
      buf_q <= buf_d;
    end
  end

  assign vld_o      = vld_q;
  assign data_o     = vld_q ? buf_q : bus_data_i;
  assign stallreq_o = ce_i && !vld_q && !ack_i;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and data access.
// One transaction at a time, data side first, at least one idle cycle between
// transactions. Results are buffered per side until the pipeline advances.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance_i,
  input  logic          flush_i,
  input  logic          if_ce_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  output logic          if_stallreq_o,
  input  logic          d_ce_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_data_i,
  input  logic [SW-1:0] d_sel_i,
  output logic [DW-1:0] d_data_o,
  output logic          d_stallreq_o,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_data_o,
  output logic [SW-1:0] m_sel_o,
  input  logic [DW-1:0] m_data_i,
  input  logic          m_ack_i
);

  bus_state_e    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          discard_q, discard_d;
  logic          d_vld, i_vld;
  logic          d_ack, i_ack;

  assign d_ack = (state_q == BUS_DATA) && m_ack_i;
  assign i_ack = (state_q == BUS_INST) && m_ack_i;

  // Next-state and registered bus outputs: requests are sampled only in IDLE.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    data_d    = data_q;
    sel_d     = sel_q;
    discard_d = discard_q;
    case (state_q)
      BUS_IDLE: begin
        if (d_ce_i && !d_vld) begin
          state_d = BUS_DATA;
          req_d   = 1'b1;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          data_d  = d_data_i;
          sel_d   = d_sel_i;
        end else if (if_ce_i && !i_vld && !flush_i) begin
          state_d = BUS_INST;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          data_d  = '0;
          sel_d   = '1;
        end
      end
      BUS_DATA, BUS_INST: begin
        if (m_ack_i) begin
          state_d = BUS_IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
    // A flush while a transaction is (or is becoming) outstanding marks its result as stale;
    // the transaction still completes and the mark is dropped on its ack.
    if (m_ack_i && state_q != BUS_IDLE) begin
      discard_d = 1'b0;
    end else if (flush_i && state_d != BUS_IDLE) begin
      discard_d = 1'b1;
    end
  end

  // State and bus output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BUS_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      discard_q <= discard_d;
    end
  end

  assign m_req_o  = req_q;
  assign m_we_o   = we_q;
  assign m_addr_o = addr_q;
  assign m_data_o = data_q;
  assign m_sel_o  = sel_q;

  arb_result_buf #(.DW(DW)) u_d_buf (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (d_ce_i),
    .ack_i      (d_ack),
    .discard_i  (discard_q),
    .advance_i  (advance_i),
    .flush_i    (flush_i),
    .keep_data_i(we_q),
    .bus_data_i (m_data_i),
    .data_o     (d_data_o),
    .vld_o      (d_vld),
    .stallreq_o (d_stallreq_o)
  );

  arb_result_buf #(.DW(DW)) u_i_buf (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (if_ce_i),
    .ack_i      (i_ack),
    .discard_i  (discard_q),
    .advance_i  (advance_i),
    .flush_i    (flush_i),
    .keep_data_i(1'b0),
    .bus_data_i (m_data_i),
    .data_o     (if_data_o),
    .vld_o      (i_vld),
    .stallreq_o (if_stallreq_o)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level expectation of the bus.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance_i, flush_i;
  logic        if_ce_i;
  logic [31:0] if_addr_i, if_data_o;
  logic        if_stallreq_o;
  logic        d_ce_i, d_we_i;
  logic [31:0] d_addr_i, d_data_i, d_data_o;
  logic [3:0]  d_sel_i;
  logic        d_stallreq_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_data_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_data_i;
  logic        m_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .advance_i    (advance_i),
    .flush_i      (flush_i),
    .if_ce_i      (if_ce_i),
    .if_addr_i    (if_addr_i),
    .if_data_o    (if_data_o),
    .if_stallreq_o(if_stallreq_o),
    .d_ce_i       (d_ce_i),
    .d_we_i       (d_we_i),
    .d_addr_i     (d_addr_i),
    .d_data_i     (d_data_i),
    .d_sel_i      (d_sel_i),
    .d_data_o     (d_data_o),
    .d_stallreq_o (d_stallreq_o),
    .m_req_o      (m_req_o),
    .m_we_o       (m_we_o),
    .m_addr_o     (m_addr_o),
    .m_data_o     (m_data_o),
    .m_sel_o      (m_sel_o),
    .m_data_i     (m_data_i),
    .m_ack_i      (m_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are driven there, outputs sampled 1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle of a bus transaction. Holds it for w wait cycles, then acks.
  // The owner stalls until the ack cycle; the other side's stall is constant meanwhile.
  task automatic serve(input string tag, input bit is_d, input bit exp_we,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_sel, input int w, input logic [31:0] rdata,
                       input bit other_stall, input bit adv);
    for (int c = 0; c <= w; c++) begin
      m_ack_i   = (c == w);
      m_data_i  = (c == w) ? rdata : $urandom;
      advance_i = (c == w) ? adv : 1'b0;
      #1;
      chk({tag, ".req"}, m_req_o, 1);
      chk({tag, ".we"}, m_we_o, exp_we);
      chk({tag, ".addr"}, m_addr_o, exp_addr);
      chk({tag, ".sel"}, m_sel_o, exp_sel);
      if (exp_we) chk({tag, ".wdata"}, m_data_o, exp_wdata);
      chk({tag, ".stall"}, is_d ? d_stallreq_o : if_stallreq_o, (c < w));
      chk({tag, ".other_stall"}, is_d ? if_stallreq_o : d_stallreq_o, other_stall);
      if (c == w && !exp_we) chk({tag, ".ack_data"}, is_d ? d_data_o : if_data_o, rdata);
      step();
    end
    m_ack_i   = 1'b0;
    advance_i = 1'b0;
    m_data_i  = $urandom;
  endtask

  // One pipeline request group: optional data access and/or fetch raised together in IDLE.
  task automatic txn(input string tag, input bit do_d, input bit do_i, input bit d_we,
                     input logic [31:0] d_addr, input logic [31:0] d_wdata, input logic [3:0] d_sel,
                     input logic [31:0] i_addr, input int wd, input int wi,
                     input logic [31:0] rd_d, input logic [31:0] rd_i, input bit adv);
    d_ce_i = do_d; d_we_i = d_we; d_addr_i = d_addr; d_data_i = d_wdata; d_sel_i = d_sel;
    if_ce_i = do_i; if_addr_i = i_addr; advance_i = 1'b0;
    #1;
    chk({tag, ".idle_req"}, m_req_o, 0);
    chk({tag, ".d_stall0"}, d_stallreq_o, do_d);
    chk({tag, ".i_stall0"}, if_stallreq_o, do_i);
    step();
    if (do_d) begin
      serve({tag, ".d"}, 1'b1, d_we, d_addr, d_wdata, d_sel, wd, rd_d, do_i, do_i ? 1'b0 : adv);
      if (do_i) begin
        #1;
        chk({tag, ".gap_req"}, m_req_o, 0);
        chk({tag, ".gap_d_stall"}, d_stallreq_o, 0);
        chk({tag, ".gap_i_stall"}, if_stallreq_o, 1);
        if (!d_we) chk({tag, ".gap_d_data"}, d_data_o, rd_d);
        step();
      end
    end
    if (do_i) serve({tag, ".i"}, 1'b0, 1'b0, i_addr, 32'h0, 4'hF, wi, rd_i, 1'b0, adv);
    if (adv) begin
      d_ce_i = 1'b0;
      if_ce_i = 1'b0;
    end
    #1;
    chk({tag, ".post_req"}, m_req_o, 0);
    if (!adv) begin
      if (do_d) chk({tag, ".post_d_stall"}, d_stallreq_o, 0);
      if (do_d && !d_we) chk({tag, ".post_d_data"}, d_data_o, rd_d);
      if (do_i) chk({tag, ".post_i_stall"}, if_stallreq_o, 0);
      if (do_i) chk({tag, ".post_i_data"}, if_data_o, rd_i);
    end
    d_ce_i = 1'b0; if_ce_i = 1'b0; advance_i = 1'b1;
    step();
    advance_i = 1'b0;
    #1;
    chk({tag, ".clr_d"}, d_data_o, m_data_i);
    chk({tag, ".clr_i"}, if_data_o, m_data_i);
    step();
  endtask

  initial begin
    rst = 1'b0; advance_i = 1'b0; flush_i = 1'b0;
    if_ce_i = 1'b0; if_addr_i = '0;
    d_ce_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_data_i = '0; d_sel_i = '0;
    m_data_i = 32'hA5A5_0001; m_ack_i = 1'b0;

    // Reset values.
    #12;
    chk("rst.req", m_req_o, 0);
    chk("rst.we", m_we_o, 0);
    chk("rst.addr", m_addr_o, 0);
    chk("rst.data", m_data_o, 0);
    chk("rst.sel", m_sel_o, 0);
    chk("rst.d_data", d_data_o, m_data_i);
    chk("rst.i_data", if_data_o, m_data_i);
    if_ce_i = 1'b1;
    #1;
    chk("rst.i_stall_comb", if_stallreq_o, 1);
    if_ce_i = 1'b0;
    rst = 1'b1;
    step();

    // Fetch only, ack two cycles after the request.
    txn("fetch", 1'b0, 1'b1, 1'b0, 0, 0, 0, 32'h0000_0010, 0, 2, 0, 32'h3401_1100, 1'b1);
    // Data read and fetch together, pipeline held.
    txn("both", 1'b1, 1'b1, 1'b0, 32'h100, 0, 4'hF, 32'h20, 1, 2, 32'hCAFE_0100, 32'h0BAD_0020, 1'b0);
    // Partial write.
    txn("write", 1'b1, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 0, 2, 0, 0, 0, 1'b0);

    // Flush while a fetch is outstanding: result dropped, fetch re-issued after IDLE.
    if_ce_i = 1'b1; if_addr_i = 32'h40;
    #1;
    chk("flush.stall0", if_stallreq_o, 1);
    step();
    flush_i = 1'b1;
    #1;
    chk("flush.req_held", m_req_o, 1);
    step();
    flush_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("flush.wait_req", m_req_o, 1);
      chk("flush.wait_stall", if_stallreq_o, 1);
      step();
    end
    m_ack_i = 1'b1; m_data_i = 32'h1234_5678;
    #1;
    chk("flush.ack_stall", if_stallreq_o, 0);
    step();
    m_ack_i = 1'b0; m_data_i = 32'h5555_AAAA;
    #1;
    chk("flush.idle_req", m_req_o, 0);
    chk("flush.not_buffered", if_stallreq_o, 1);
    chk("flush.i_data_live", if_data_o, 32'h5555_AAAA);
    step();
    serve("flush.reissue", 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 0, 32'h7777_0040, 1'b0, 1'b1);
    if_ce_i = 1'b0;
    step();

    // Zero-wait ack with the pipeline advancing: nothing buffered, re-issue after one IDLE cycle.
    if_ce_i = 1'b1; if_addr_i = 32'h80;
    #1;
    chk("zw.stall0", if_stallreq_o, 1);
    step();
    serve("zw.first", 1'b0, 1'b0, 32'h80, 32'h0, 4'hF, 0, 32'h0000_0080, 1'b0, 1'b1);
    #1;
    chk("zw.idle_req", m_req_o, 0);
    chk("zw.idle_stall", if_stallreq_o, 1);
    step();
    serve("zw.second", 1'b0, 1'b0, 32'h80, 32'h0, 4'hF, 1, 32'h0000_0081, 1'b0, 1'b1);
    if_ce_i = 1'b0;
    step();

    // Randomized request groups.
    for (int n = 0; n < 40; n++) begin
      bit do_d, do_i;
      int kind;
      kind = $urandom_range(0, 2);
      do_d = (kind != 0);
      do_i = (kind != 1);
      txn("rand", do_d, do_i, 1'($urandom), {$urandom_range(0, 32'hFFFF), 2'b00},
          $urandom, 4'($urandom), {$urandom_range(0, 32'hFFFF), 2'b00},
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom, 1'($urandom));
    end

    // Reset while a data transaction is outstanding.
    d_ce_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h300; d_data_i = 32'h0102_0304; d_sel_i = 4'hF;
    step();
    #1;
    chk("rmid.req", m_req_o, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("rmid.req_async", m_req_o, 0);
    chk("rmid.we", m_we_o, 0);
    chk("rmid.addr", m_addr_o, 0);
    chk("rmid.data", m_data_o, 0);
    chk("rmid.sel", m_sel_o, 0);
    d_ce_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    #1;
    chk("rmid.idle_req", m_req_o, 0);
    chk("rmid.d_stall", d_stallreq_o, 0);
    step();
    txn("after_rst", 1'b0, 1'b1, 1'b0, 0, 0, 0, 32'h0000_0C00, 0, 1, 0, 32'h0C0C_0C0C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
